// File: rtl/alu_issue_seq.sv
// Execute-stage sequencer: drives a combinational add/sub ALU for two cycles per
// instruction (rd/branch compare, then next PC) and hands the result downstream.
module alu_issue_seq #(
  parameter int DATA_LEN = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [3:0]          in_op,
  input  logic [DATA_LEN-1:0] in_pc,
  input  logic [DATA_LEN-1:0] in_rs1,
  input  logic [DATA_LEN-1:0] in_rs2,
  input  logic [DATA_LEN-1:0] in_imm,
  output logic [DATA_LEN-1:0] alu_src1,
  output logic [DATA_LEN-1:0] alu_src2,
  output logic [3:0]          alu_control,
  input  logic [DATA_LEN-1:0] alu_result,
  input  logic                alu_zero,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_LEN-1:0] out_rd_wdata,
  output logic                out_rd_wen,
  output logic [DATA_LEN-1:0] out_next_pc,
  output logic                out_illegal
);

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_ADDI  = 4'd2;
  localparam logic [3:0] OP_LUI   = 4'd3;
  localparam logic [3:0] OP_AUIPC = 4'd4;
  localparam logic [3:0] OP_JAL   = 4'd5;
  localparam logic [3:0] OP_JALR  = 4'd6;
  localparam logic [3:0] OP_BEQ   = 4'd7;
  localparam logic [3:0] OP_BNE   = 4'd8;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;

  localparam logic [DATA_LEN-1:0] PC_STEP = DATA_LEN'(4);

  typedef enum logic [1:0] {IDLE, EX1, EX2, DONE} state_t;

  state_t              state_reg;
  logic [3:0]          op_reg;
  logic [DATA_LEN-1:0] pc_reg;
  logic [DATA_LEN-1:0] rs1_reg;
  logic [DATA_LEN-1:0] rs2_reg;
  logic [DATA_LEN-1:0] imm_reg;
  logic                taken_reg;
  logic [DATA_LEN-1:0] rd_wdata_reg;
  logic                rd_wen_reg;
  logic [DATA_LEN-1:0] next_pc_reg;
  logic                illegal_reg;

  logic is_branch;

  assign in_ready     = (state_reg == IDLE);
  assign out_valid    = (state_reg == DONE);
  assign out_rd_wdata = rd_wdata_reg;
  assign out_rd_wen   = rd_wen_reg;
  assign out_next_pc  = next_pc_reg;
  assign out_illegal  = illegal_reg;
  assign is_branch    = (op_reg == OP_BEQ) || (op_reg == OP_BNE);

  // ALU operand selection; the bus is parked at zero outside the two EX cycles.
  always_comb begin
    alu_src1    = '0;
    alu_src2    = '0;
    alu_control = ALU_ADD;
    if (state_reg == EX1) begin
      unique case (op_reg)
        OP_ADD:          begin alu_src1 = rs1_reg; alu_src2 = rs2_reg; end
        OP_SUB:          begin alu_src1 = rs1_reg; alu_src2 = rs2_reg; alu_control = ALU_SUB; end
        OP_ADDI:         begin alu_src1 = rs1_reg; alu_src2 = imm_reg; end
        OP_LUI:          begin alu_src1 = '0;      alu_src2 = imm_reg; end
        OP_AUIPC:        begin alu_src1 = pc_reg;  alu_src2 = imm_reg; end
        OP_JAL, OP_JALR: begin alu_src1 = pc_reg;  alu_src2 = PC_STEP; end
        OP_BEQ, OP_BNE:  begin alu_src1 = rs1_reg; alu_src2 = rs2_reg; alu_control = ALU_SUB; end
        default:         begin alu_src1 = '0;      alu_src2 = '0; end
      endcase
    end else if (state_reg == EX2) begin
      alu_src1 = pc_reg;
      alu_src2 = PC_STEP;
      if (op_reg == OP_JAL) begin
        alu_src2 = imm_reg;
      end else if (op_reg == OP_JALR) begin
        alu_src1 = rs1_reg;
        alu_src2 = imm_reg;
      end else if (is_branch) begin
        alu_src2 = taken_reg ? imm_reg : PC_STEP;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      op_reg       <= '0;
      pc_reg       <= '0;
      rs1_reg      <= '0;
      rs2_reg      <= '0;
      imm_reg      <= '0;
      taken_reg    <= 1'b0;
      rd_wdata_reg <= '0;
      rd_wen_reg   <= 1'b0;
      next_pc_reg  <= '0;
      illegal_reg  <= 1'b0;
    end else begin
      unique case (state_reg)
        IDLE: begin
          if (in_valid) begin
            op_reg  <= in_op;
            pc_reg  <= in_pc;
            rs1_reg <= in_rs1;
            rs2_reg <= in_rs2;
            imm_reg <= in_imm;
            if (in_op > OP_BNE) begin
              // Illegal ops skip the ALU and report straight away.
              illegal_reg  <= 1'b1;
              rd_wen_reg   <= 1'b0;
              rd_wdata_reg <= '0;
              next_pc_reg  <= in_pc;
              state_reg    <= DONE;
            end else begin
              illegal_reg <= 1'b0;
              state_reg   <= EX1;
            end
          end
        end
        EX1: begin
          if (is_branch) begin
            taken_reg  <= (op_reg == OP_BEQ) ? alu_zero : !alu_zero;
            rd_wen_reg <= 1'b0;
          end else begin
            rd_wdata_reg <= alu_result;
            rd_wen_reg   <= 1'b1;
          end
          state_reg <= EX2;
        end
        EX2: begin
          if (op_reg == OP_JALR) begin
            next_pc_reg <= {alu_result[DATA_LEN-1:1], 1'b0};
          end else begin
            next_pc_reg <= alu_result;
          end
          state_reg <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_seq.sv
// Scoreboard bench for alu_issue_seq: a driver pushes spec-derived expectations,
// a negedge monitor checks the ALU drive, handshakes, latency and result bundle.
module tb_alu_issue_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [31:0] in_pc, in_rs1, in_rs2, in_imm;
  logic [31:0] alu_src1, alu_src2, alu_result;
  logic [3:0]  alu_control;
  logic        alu_zero;
  logic        out_valid, out_ready;
  logic [31:0] out_rd_wdata, out_next_pc;
  logic        out_rd_wen, out_illegal;

  always #5 clk = ~clk;

  alu_issue_seq #(.DATA_LEN(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_pc(in_pc), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_control(alu_control),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rd_wdata(out_rd_wdata), .out_rd_wen(out_rd_wen),
    .out_next_pc(out_next_pc), .out_illegal(out_illegal)
  );

  // Combinational ALU behind the interface.
  assign alu_result = (alu_control == 4'b0001) ? alu_src1 - alu_src2 : alu_src1 + alu_src2;
  assign alu_zero   = (alu_result == 32'd0);

  typedef struct {
    logic [3:0]  op;
    logic [31:0] pc, rs1, rs2, imm, rd, npc;
    logic        wen, ill, chk_wd, seen;
    int          lat;
    int          acc_cyc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   rand_ready = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (rand_ready) begin
      #1 out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference model: architectural effect of one instruction.
  function automatic exp_t model(input logic [3:0] op, input logic [31:0] pc, rs1, rs2, imm);
    exp_t e;
    e.op = op; e.pc = pc; e.rs1 = rs1; e.rs2 = rs2; e.imm = imm;
    e.seen = 1'b0; e.acc_cyc = 0;
    e.ill = (op > 4'd8);
    e.lat = e.ill ? 1 : 3;
    e.wen = !e.ill && op != 4'd7 && op != 4'd8;
    e.chk_wd = e.wen || e.ill;
    e.rd = 32'd0;
    e.npc = pc + 32'd4;
    case (op)
      4'd0: e.rd = rs1 + rs2;
      4'd1: e.rd = rs1 - rs2;
      4'd2: e.rd = rs1 + imm;
      4'd3: e.rd = imm;
      4'd4: e.rd = pc + imm;
      4'd5: begin e.rd = pc + 32'd4; e.npc = pc + imm; end
      4'd6: begin e.rd = pc + 32'd4; e.npc = (rs1 + imm) & ~32'd1; end
      4'd7: e.npc = (rs1 == rs2) ? pc + imm : pc + 32'd4;
      4'd8: e.npc = (rs1 != rs2) ? pc + imm : pc + 32'd4;
      default: e.npc = pc;
    endcase
    return e;
  endfunction

  // Expected ALU drive for the two operation cycles (ph = 1 or 2).
  task automatic exp_alu(input exp_t e, input int ph,
                         output logic [31:0] s1, output logic [31:0] s2, output logic [3:0] c);
    logic taken;
    taken = (e.op == 4'd7) ? (e.rs1 == e.rs2) : (e.rs1 != e.rs2);
    c = 4'd0; s1 = e.pc; s2 = 32'd4;
    if (ph == 1) begin
      case (e.op)
        4'd0: begin s1 = e.rs1; s2 = e.rs2; end
        4'd1, 4'd7, 4'd8: begin s1 = e.rs1; s2 = e.rs2; c = 4'd1; end
        4'd2: begin s1 = e.rs1; s2 = e.imm; end
        4'd3: begin s1 = 32'd0; s2 = e.imm; end
        4'd4: s2 = e.imm;
        default: ;
      endcase
    end else begin
      case (e.op)
        4'd5: s2 = e.imm;
        4'd6: begin s1 = e.rs1; s2 = e.imm; end
        4'd7, 4'd8: s2 = taken ? e.imm : 32'd4;
        default: ;
      endcase
    end
  endtask

  // Monitor: every negedge outside reset.
  always @(negedge clk) begin
    logic [31:0] s1, s2;
    logic [3:0]  c;
    int          d;
    if (!rst) begin
      check("in_ready", in_ready, (q.size() == 0) || (q[$].acc_cyc == cyc));
      if (q.size() == 0) begin
        check("idle_quiet", {out_valid, alu_control, alu_src1, alu_src2}, '0);
      end else begin
        d = cyc - q[0].acc_cyc;
        if (q[0].lat == 3 && (d == 1 || d == 2)) begin
          exp_alu(q[0], d, s1, s2, c);
          check("ex_ctrl", alu_control, c);
          check("ex_src1", alu_src1, s1);
          check("ex_src2", alu_src2, s2);
        end
        if (out_valid) begin
          if (!q[0].seen) begin
            check("latency", d, q[0].lat);
            q[0].seen = 1'b1;
          end
          check("rd_wen", out_rd_wen, q[0].wen);
          check("next_pc", out_next_pc, q[0].npc);
          check("illegal", out_illegal, q[0].ill);
          if (q[0].chk_wd) check("rd_wdata", out_rd_wdata, q[0].rd);
          if (out_ready) begin
            $display("txn op=%0d pc=%08h rd=%08h wen=%0b npc=%08h ill=%0b",
                     q[0].op, q[0].pc, out_rd_wdata, out_rd_wen, out_next_pc, out_illegal);
            void'(q.pop_front());
          end
        end
      end
    end
  end

  // Called and returning at posedge+1.
  task automatic issue(input logic [3:0] op, input logic [31:0] pc, rs1, rs2, imm);
    exp_t e;
    int   n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      errors++; checks++;
      $display("FAIL issue_timeout: in_ready=0 after %0d cycles, required 1", n);
      return;
    end
    in_valid = 1'b1; in_op = op; in_pc = pc; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
    e = model(op, pc, rs1, rs2, imm);
    e.acc_cyc = cyc;
    q.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (q.size() != 0) begin
      errors++; checks++;
      $display("FAIL drain_timeout: %0d bundles pending, required 0", q.size());
      q.delete();
    end
  endtask

  initial begin
    logic [3:0]  op;
    logic [31:0] a, b;
    rst = 1'b1; in_valid = 1'b0; in_op = '0; in_pc = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_outputs", {out_valid, out_rd_wdata, out_rd_wen, out_next_pc, out_illegal}, '0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    issue(4'd0, 32'h100, 32'd5, 32'd7, 32'd0);            // ADD
    drain();
    issue(4'd7, 32'h200, 32'h1234, 32'h1234, 32'hFFFF_FFF8); // BEQ taken
    drain();
    issue(4'd8, 32'h200, 32'h1234, 32'h1234, 32'hFFFF_FFF8); // BNE not taken
    drain();
    issue(4'd6, 32'h300, 32'h1001, 32'd0, 32'd4);         // JALR
    drain();
    issue(4'd12, 32'h500, 32'd1, 32'd2, 32'd3);           // illegal
    drain();

    // Backpressure: hold the bundle for 5 cycles.
    out_ready = 1'b0;
    issue(4'd2, 32'h600, 32'hFFFF_FFFF, 32'd0, 32'd1);
    begin
      int n = 0;
      while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
    end
    repeat (5) @(posedge clk);
    #1 out_ready = 1'b1;
    drain();

    // Randomized traffic with random backpressure.
    rand_ready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      op = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
      a  = $urandom;
      b  = ($urandom_range(0, 1) == 1) ? a : $urandom;
      issue(op, $urandom, a, b, $urandom);
    end
    drain();
    rand_ready = 1'b0;
    @(posedge clk); #1 out_ready = 1'b1;

    // Reset during EX2 of a JAL.
    issue(4'd5, 32'h400, 32'd0, 32'd0, 32'h40);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("midrst_in_ready", in_ready, 1'b1);
    check("midrst_outputs", {out_valid, out_rd_wdata, out_rd_wen, out_next_pc, out_illegal}, '0);
    check("midrst_alu", {alu_control, alu_src1, alu_src2}, '0);
    q.delete();
    @(negedge clk) rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    issue(4'd3, 32'h700, 32'd0, 32'd0, 32'hABCD_E000);   // LUI after reset
    drain();
    repeat (2) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
